ram_arbiter: RTL and testbench

//  Shares the slave RAM's 10-bit command port between NUM_REQ requesters (SPI slave, debug/BIST port).

---
 rtl/spi_ram_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/ram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared types and widths for the slave-RAM command path.
//   ram_cmd_e   : 2-bit command code carried in din[9:8] of every RAM beat
//   arb_state_e : transaction FSM states of ram_arbiter
//   RAM_AW/DW   : RAM address and data widths (8 bits each)
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        WADDR = 2'b00,
        WDATA = 2'b01,
        RADDR = 2'b10,
        RDATA = 2'b11
    } ram_cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        WAIT_RD = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the winner is the first set request bit
// found when searching upward from ptr+1, wrapping past NUM_REQ-1 to 0.
// Ports:
//   req       in   NUM_REQ   request vector
//   ptr       in   IW        index of the most recent winner
//   grant     out  NUM_REQ   one-hot winner (all zero when no request)
//   grant_idx out  IW        binary index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic          found;
    int            idx;
    logic [IW-1:0] sel;

    // Walk the requesters in priority order starting just after ptr; the
    // first hit wins, later hits are masked by 'found'.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares the slave RAM 10-bit command port between NUM_REQ requesters.
// Whole transactions are granted round-robin and expanded into an address
// beat and a data beat; reads then wait for ram_tx_valid (or time out).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/we/addr/wdata  per-requester request, held until req_ready
//   req_ready                one-hot 1-cycle accept pulse
//   rsp_valid                one-hot 1-cycle completion pulse to the owner
//   rsp_rdata, rsp_err       read data / timeout flag, valid with rsp_valid
//   ram_rx_valid, ram_din    command strobe and {cmd, payload} to the RAM
//   ram_dout, ram_tx_valid   read data and its valid strobe from the RAM
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*RAM_AW-1:0] req_addr,
    input  logic [NUM_REQ*RAM_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RAM_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      ram_rx_valid,
    output logic [RAM_DW+1:0]         ram_din,
    input  logic [RAM_DW-1:0]         ram_dout,
    input  logic                      ram_tx_valid
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [RAM_DW-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  owner_q, owner_d;
    logic                wr_pend_q, wr_pend_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [RAM_DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                ram_rx_valid_q, ram_rx_valid_d;
    logic [RAM_DW+1:0]   ram_din_q, ram_din_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       grant_idx;
    logic                sel_we;
    logic [RAM_AW-1:0]   sel_addr;
    logic [RAM_DW-1:0]   sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot mux of the winning requester's fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*RAM_AW +: RAM_AW];
                sel_wdata = req_wdata[i*RAM_DW +: RAM_DW];
            end
        end
    end

    // The state names the beat about to be registered onto the outputs, so
    // each output appears one cycle after the state that produces it. A write
    // completes from the IDLE that follows DATA (wr_pend), which keeps its
    // response at T+3 while still letting IDLE arbitrate on the same edge.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        owner_d        = owner_q;
        wr_pend_d      = 1'b0;
        cnt_d          = cnt_q;
        req_ready_d    = '0;
        rsp_valid_d    = '0;
        rsp_rdata_d    = '0;
        rsp_err_d      = 1'b0;
        ram_rx_valid_d = 1'b0;
        ram_din_d      = '0;

        unique case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    rsp_valid_d = owner_q;
                end
                if (|req_valid) begin
                    req_ready_d = grant;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    owner_d     = grant;
                    ptr_d       = grant_idx;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {(we_q ? WADDR : RADDR), addr_q};
                state_d        = DATA;
            end
            DATA: begin
                ram_rx_valid_d = 1'b1;
                cnt_d          = '0;
                if (we_q) begin
                    ram_din_d = {WDATA, wdata_q};
                    wr_pend_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ram_din_d = {RDATA, {RAM_DW{1'b0}}};
                    state_d   = WAIT_RD;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (ram_tx_valid) begin
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = ram_dout;
                    state_d     = IDLE;
                end else if (cnt_q + 1'b1 == CW'(RD_TIMEOUT)) begin
                    rsp_valid_d = owner_q;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves ptr on the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= IW'(NUM_REQ - 1);
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            owner_q        <= '0;
            wr_pend_q      <= 1'b0;
            cnt_q          <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            ram_rx_valid_q <= 1'b0;
            ram_din_q      <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            owner_q        <= owner_d;
            wr_pend_q      <= wr_pend_d;
            cnt_q          <= cnt_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            ram_din_q      <= ram_din_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign ram_din      = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural RAM model. Expected
// grants, RAM beats and responses are queued when stimulus is issued; a
// monitor on the falling edge pops and compares whenever the DUT shows
// req_ready, ram_rx_valid or rsp_valid, including cycle offsets from accept.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int RD_TIMEOUT = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_we;
    logic [NUM_REQ*8-1:0]    req_addr;
    logic [NUM_REQ*8-1:0]    req_wdata;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [7:0]              rsp_rdata;
    logic                    rsp_err;
    logic                    ram_rx_valid;
    logic [9:0]              ram_din;
    logic [7:0]              ram_dout;
    logic                    ram_tx_valid;

    ram_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_rx_valid (ram_rx_valid),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: latches the address beat, writes on WDATA, and answers an
    // RDATA beat on the following cycle unless hold_low is set.
    logic [7:0] mem [256];
    logic [7:0] ram_a    = 8'h00;
    logic       model_tx = 1'b0;
    logic       hold_low = 1'b0;
    logic       spur     = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_dout = 8'h00;
    end

    always @(posedge clk) begin
        model_tx <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00, 2'b10: ram_a <= ram_din[7:0];
                2'b01:        mem[ram_a] <= ram_din[7:0];
                default: begin
                    if (!hold_low) begin
                        model_tx <= 1'b1;
                        ram_dout <= mem[ram_a];
                    end
                end
            endcase
        end
    end

    assign ram_tx_valid = model_tx | spur;

    typedef struct {
        int         owner;
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } rsp_t;

    rsp_t       exp_rsp [$];
    logic [9:0] exp_din [$];
    int         exp_gnt [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: responses are checked before grants so a write response and
    // the next accept landing in the same cycle are timed correctly.
    int   acc_cyc = -100;
    int   beat    = 0;
    rsp_t mon_e;
    int   mon_g;

    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = exp_rsp.pop_front();
                checkOutput("rsp_owner", 32'(rsp_valid), 32'(1 << mon_e.owner));
                checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                checkOutput("rsp_err",   32'(rsp_err),   32'(mon_e.err));
                if (mon_e.lat != 0) checkOutput("rsp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
            end
        end
        if (req_ready != '0) begin
            if (exp_gnt.size() == 0) begin
                checkOutput("unexpected_grant", 32'(req_ready), 32'd0);
            end else begin
                mon_g = exp_gnt.pop_front();
                checkOutput("grant", 32'(req_ready), 32'(1 << mon_g));
            end
            acc_cyc = cyc;
            beat    = 0;
        end
        if (ram_rx_valid) begin
            beat++;
            if (exp_din.size() == 0) begin
                checkOutput("unexpected_din", 32'(ram_din), 32'd0);
            end else begin
                checkOutput("ram_din", 32'(ram_din), 32'(exp_din.pop_front()));
                checkOutput("din_latency", 32'(cyc - acc_cyc), 32'(beat));
            end
        end
    end

    // Queue one accepted transaction: grant owner, both RAM beats, response.
    task automatic expectTxn(input int owner, input logic [9:0] d0, input logic [9:0] d1,
                             input logic [7:0] rdata, input logic err, input int lat);
        rsp_t e;
        e.owner = owner; e.rdata = rdata; e.err = err; e.lat = lat;
        exp_gnt.push_back(owner);
        exp_din.push_back(d0);
        exp_din.push_back(d1);
        exp_rsp.push_back(e);
    endtask

    // Raise a request and hold it until accepted; returns on the falling
    // edge of the accept cycle.
    task automatic applyStimulus(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        req_valid[i]       = 1'b1;
        req_we[i]          = we;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        req_valid[i] = 1'b0;
        checkOutput("accept_wait", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int left;
        left = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            left = exp_rsp.size() + exp_din.size() + exp_gnt.size();
            if (left == 0) break;
        end
        checkOutput("drain_pending", 32'(left), 32'd0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready",    32'(req_ready),    32'd0);
        checkOutput("reset_rsp_valid",    32'(rsp_valid),    32'd0);
        checkOutput("reset_rsp_rdata",    32'(rsp_rdata),    32'd0);
        checkOutput("reset_rsp_err",      32'(rsp_err),      32'd0);
        checkOutput("reset_ram_rx_valid", 32'(ram_rx_valid), 32'd0);
        checkOutput("reset_ram_din",      32'(ram_din),      32'd0);
        rst = 1'b0;

        $display("[TB] test 1: write then read back");
        expectTxn(0, 10'h012, 10'h1A5, 8'h00, 1'b0, 3);
        applyStimulus(0, 1'b1, 8'h12, 8'hA5);
        drain();
        expectTxn(1, 10'h212, 10'h300, 8'hA5, 1'b0, 4);
        applyStimulus(1, 1'b0, 8'h12, 8'h00);
        drain();

        $display("[TB] test 2: round-robin with both requesters busy");
        applyReset();
        expectTxn(0, 10'h020, 10'h101, 8'h00, 1'b0, 3);
        expectTxn(1, 10'h021, 10'h102, 8'h00, 1'b0, 3);
        expectTxn(0, 10'h022, 10'h103, 8'h00, 1'b0, 3);
        expectTxn(1, 10'h023, 10'h104, 8'h00, 1'b0, 3);
        fork
            begin
                applyStimulus(0, 1'b1, 8'h20, 8'h01);
                applyStimulus(0, 1'b1, 8'h22, 8'h03);
            end
            begin
                applyStimulus(1, 1'b1, 8'h21, 8'h02);
                applyStimulus(1, 1'b1, 8'h23, 8'h04);
            end
        join
        drain();

        $display("[TB] test 3: address boundaries");
        expectTxn(0, 10'h000, 10'h111, 8'h00, 1'b0, 3);
        applyStimulus(0, 1'b1, 8'h00, 8'h11);
        drain();
        expectTxn(1, 10'h0FF, 10'h1EE, 8'h00, 1'b0, 3);
        applyStimulus(1, 1'b1, 8'hFF, 8'hEE);
        drain();
        expectTxn(0, 10'h200, 10'h300, 8'h11, 1'b0, 4);
        applyStimulus(0, 1'b0, 8'h00, 8'h00);
        drain();
        expectTxn(1, 10'h2FF, 10'h300, 8'hEE, 1'b0, 4);
        applyStimulus(1, 1'b0, 8'hFF, 8'h00);
        drain();

        $display("[TB] test 4: read timeout");
        hold_low = 1'b1;
        expectTxn(0, 10'h212, 10'h300, 8'h00, 1'b1, 0);
        applyStimulus(0, 1'b0, 8'h12, 8'h00);
        drain();
        hold_low = 1'b0;
        expectTxn(1, 10'h212, 10'h300, 8'hA5, 1'b0, 4);
        applyStimulus(1, 1'b0, 8'h12, 8'h00);
        drain();

        $display("[TB] test 5: reset during a read");
        exp_gnt.push_back(0);
        exp_din.push_back(10'h230);
        expectTxn(1, 10'h040, 10'h177, 8'h00, 1'b0, 3);
        applyStimulus(0, 1'b0, 8'h30, 8'h00);
        fork
            applyStimulus(1, 1'b1, 8'h40, 8'h77);
            begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("abort_rx_valid",  32'(ram_rx_valid), 32'd0);
                checkOutput("abort_din",       32'(ram_din),      32'd0);
                checkOutput("abort_rsp_valid", 32'(rsp_valid),    32'd0);
                checkOutput("abort_req_ready", 32'(req_ready),    32'd0);
                rst = 1'b0;
            end
        join
        drain();

        $display("[TB] test 6: spurious ram_tx_valid");
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        expectTxn(0, 10'h050, 10'h1C3, 8'h00, 1'b0, 3);
        applyStimulus(0, 1'b1, 8'h50, 8'hC3);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        drain();
        expectTxn(1, 10'h250, 10'h300, 8'hC3, 1'b0, 4);
        applyStimulus(1, 1'b0, 8'h50, 8'h00);
        drain();
        expectTxn(0, 10'h240, 10'h300, 8'h77, 1'b0, 4);
        applyStimulus(0, 1'b0, 8'h40, 8'h00);
        drain();

        repeat (5) @(negedge clk);
        checkOutput("leftover_expectations",
                    32'(exp_rsp.size() + exp_din.size() + exp_gnt.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
